// File: rtl/systolic_job_arbiter.sv
// systolic_job_arbiter: round-robin sharing of one systolic controller, with in-order result steering by tag FIFO
module systolic_job_arbiter #(
    parameter int NREQ      = 3,
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 9,
    parameter int MAX_OUT   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req_valid,
    output logic [NREQ-1:0]                    req_ready,
    input  logic [NREQ*ROWS*ROWS*WIDTH-1:0]    req_a_flat,
    input  logic [NREQ*ROWS*COLS*WIDTH-1:0]    req_b_flat,
    output logic                               ctl_in_valid,
    input  logic                               ctl_in_ready,
    output logic [ROWS*ROWS*WIDTH-1:0]         ctl_a_flat,
    output logic [ROWS*COLS*WIDTH-1:0]         ctl_b_flat,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]     ctl_c_flat,
    input  logic                               ctl_out_valid,
    output logic [NREQ-1:0]                    resp_valid,
    output logic [ROWS*COLS*ACC_WIDTH-1:0]     resp_c_flat,
    output logic [$clog2(NREQ)-1:0]            resp_id,
    output logic                               busy,
    output logic                               err_orphan
);
    localparam int AW  = ROWS*ROWS*WIDTH;
    localparam int BW  = ROWS*COLS*WIDTH;
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int OW  = $clog2(MAX_OUT+1);

    typedef enum logic {S_ARB, S_HOLD} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   rr_ptr, grant, pick;
    logic             any, start, push, pop;
    logic [OW-1:0]    outstanding;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [IDW-1:0]   tags [MAX_OUT];

    function automatic logic [IDW-1:0] rr_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IDW'(s >= NREQ ? s - NREQ : s);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT-1)) ? '0 : p + 1'b1;
    endfunction

    // Scan downward so the closest requester to rr_ptr overrides farther ones.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req_valid[rr_add(rr_ptr, k)]) begin
                pick = rr_add(rr_ptr, k);
                any  = 1'b1;
            end
        end
    end

    always_comb begin
        start        = state == S_ARB && any && outstanding < OW'(MAX_OUT);
        push         = state == S_HOLD && ctl_in_ready;
        pop          = ctl_out_valid && outstanding != '0;
        state_n      = state == S_ARB ? (start ? S_HOLD : S_ARB) : (ctl_in_ready ? S_ARB : S_HOLD);
        ctl_in_valid = state == S_HOLD;
        req_ready    = push ? NREQ'(1) << grant : '0;
        ctl_a_flat   = req_a_flat[grant*AW +: AW];
        ctl_b_flat   = req_b_flat[grant*BW +: BW];
        busy         = outstanding != '0 || state == S_HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ARB;
            rr_ptr      <= '0;
            grant       <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            resp_valid  <= '0;
            resp_c_flat <= '0;
            resp_id     <= '0;
            err_orphan  <= 1'b0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding + OW'(push) - OW'(pop);
            resp_valid  <= pop ? NREQ'(1) << tags[rd_ptr] : '0;
            if (start) grant <= pick;
            if (push) begin
                tags[wr_ptr] <= grant;
                wr_ptr       <= ptr_inc(wr_ptr);
                rr_ptr       <= rr_add(grant, 1);
            end
            if (pop) begin
                rd_ptr      <= ptr_inc(rd_ptr);
                resp_id     <= tags[rd_ptr];
                resp_c_flat <= ctl_c_flat;
            end
            if (ctl_out_valid && !pop) err_orphan <= 1'b1;
        end
    end
endmodule
